// File: rtl/br_miss_recovery_if.sv
// Branch/jump resolution bundle between the execute-stage comparator, the ROB,
// fetch and the direction predictor; the recovery block is the slave side.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef RobDepth
`define RobDepth 8
`endif

interface br_miss_recovery_if #(
  parameter int ADDR      = `AddrWidth,
  parameter int ROB_DEPTH = `RobDepth
);
  localparam int ROB = $clog2(ROB_DEPTH);

  logic            res_valid;
  logic            is_branch;
  logic [ROB-1:0]  rob_id;
  logic            br_res;
  logic            pred_miss_;
  logic            jump_miss_;
  logic [ADDR-1:0] target_addr;
  logic [ADDR-1:0] fall_addr;
  logic [ADDR-1:0] br_pc;
  logic [ROB-1:0]  rob_head;
  logic            flush_req;
  logic [ROB-1:0]  flush_rob_id;
  logic            flush_ack;
  logic            redirect_valid;
  logic [ADDR-1:0] redirect_addr;
  logic            redirect_ready;
  logic            upd_valid;
  logic [ADDR-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_ready;
  logic            recovering;

  modport slave (
    input  res_valid, is_branch, rob_id, br_res, pred_miss_, jump_miss_,
           target_addr, fall_addr, br_pc, rob_head, flush_ack,
           redirect_ready, upd_ready,
    output flush_req, flush_rob_id, redirect_valid, redirect_addr,
           upd_valid, upd_pc, upd_taken, recovering
  );

  modport master (
    output res_valid, is_branch, rob_id, br_res, pred_miss_, jump_miss_,
           target_addr, fall_addr, br_pc, rob_head, flush_ack,
           redirect_ready, upd_ready,
    input  flush_req, flush_rob_id, redirect_valid, redirect_addr,
           upd_valid, upd_pc, upd_taken, recovering
  );
endinterface

// File: rtl/br_miss_recovery.sv
// Misprediction recovery: picks the oldest miss, sequences ROB flush then fetch
// redirect, and queues predictor updates. Define BR_RECOVERY_STAT_EN for counters.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef RobDepth
`define RobDepth 8
`endif
`ifndef BrTaken
`define BrTaken 1'b1
`endif
`ifndef BrNTaken
`define BrNTaken 1'b0
`endif

module br_miss_recovery #(
  parameter int ADDR      = `AddrWidth,
  parameter int ROB_DEPTH = `RobDepth,
  parameter int UPD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  br_miss_recovery_if.slave   bus
`ifdef BR_RECOVERY_STAT_EN
  ,
  output logic [31:0]         stat_br_miss,
  output logic [31:0]         stat_jump_miss,
  output logic [31:0]         stat_upd_drop
`endif
);
  localparam int ROB   = $clog2(ROB_DEPTH);
  localparam int PTR   = $clog2(UPD_DEPTH);
  localparam int ENTRY = ADDR + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ROB-1:0]  cap_tag_q, cap_tag_d;
  logic [ADDR-1:0] cap_addr_q, cap_addr_d;
  logic            flush_req_q, flush_req_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            recovering_q, recovering_d;

  logic            miss_ev;
  logic [ADDR-1:0] miss_addr;
  logic [ROB-1:0]  new_age;
  logic [ROB-1:0]  cap_age;
  logic            older_miss;
  logic            not_younger;
  logic            capture;

  // Ages are relative to the live ROB head, so the captured tag is re-aged every cycle.
  always_comb begin
    miss_ev     = bus.res_valid && (!bus.pred_miss_ || !bus.jump_miss_);
    miss_addr   = bus.target_addr;
    if (!bus.pred_miss_ && (bus.br_res == `BrNTaken)) begin
      miss_addr = bus.fall_addr;
    end
    new_age     = bus.rob_id - bus.rob_head;
    cap_age     = cap_tag_q - bus.rob_head;
    older_miss  = new_age < cap_age;
    not_younger = new_age <= cap_age;
  end

  always_comb begin
    state_d    = state_q;
    cap_tag_d  = cap_tag_q;
    cap_addr_d = cap_addr_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_ev) begin
          capture = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // An older miss beats a simultaneous flush_ack: the flush must restart.
        if (miss_ev && older_miss) begin
          capture = 1'b1;
        end else if (bus.flush_ack) begin
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      cap_tag_d  = bus.rob_id;
      cap_addr_d = miss_addr;
    end
    flush_req_d      = (state_d == S_FLUSH);
    redirect_valid_d = (state_d == S_REDIRECT);
    recovering_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cap_tag_q        <= '0;
      cap_addr_q       <= '0;
      flush_req_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      recovering_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      cap_tag_q        <= cap_tag_d;
      cap_addr_q       <= cap_addr_d;
      flush_req_q      <= flush_req_d;
      redirect_valid_q <= redirect_valid_d;
      recovering_q     <= recovering_d;
    end
  end

  assign bus.flush_req      = flush_req_q;
  assign bus.flush_rob_id   = cap_tag_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_addr  = cap_addr_q;
  assign bus.recovering     = recovering_q;

  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR:0]     count_q, count_d;
  logic [ENTRY-1:0] upd_mem [UPD_DEPTH];
  logic [UPD_DEPTH-1:0] entry_we;
  logic [ENTRY-1:0] head_entry;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;

  // Branches younger than the one being flushed are squashed and never train the predictor.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (PTR + 1)'(UPD_DEPTH));
    push_req   = bus.res_valid && bus.is_branch &&
                 ((state_q == S_IDLE) || ((state_q == S_FLUSH) && not_younger));
    pop        = !fifo_empty && bus.upd_ready;
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR'(1) : wr_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR + 1)'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < UPD_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push && (wr_ptr_q == PTR'(gi));
    end
  endgenerate

  // Storage carries no reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < UPD_DEPTH; i++) begin
      if (entry_we[i]) begin
        upd_mem[i] <= {bus.br_pc, bus.br_res};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_entry    = fifo_empty ? '0 : upd_mem[rd_ptr_q];
  assign bus.upd_valid = !fifo_empty;
  assign bus.upd_pc    = head_entry[ENTRY-1:1];
  assign bus.upd_taken = head_entry[0];

`ifdef BR_RECOVERY_STAT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] jump_cnt_q, jump_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    br_cnt_d   = br_cnt_q;
    jump_cnt_d = jump_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (capture && !bus.pred_miss_ && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (capture && bus.pred_miss_ && (jump_cnt_q != '1)) begin
      jump_cnt_d = jump_cnt_q + 32'd1;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q   <= '0;
      jump_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      jump_cnt_q <= jump_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_br_miss   = br_cnt_q;
  assign stat_jump_miss = jump_cnt_q;
  assign stat_upd_drop  = drop_cnt_q;
`endif
endmodule

// File: doc/br_miss_recovery.md
Name: br_miss_recovery

Overview:
Receiving end of the branch/jump resolution interface driven by the execute-stage branch comparator. Consumes per-cycle resolution results (rob_id, br_res, active-low pred_miss_/jump_miss_) and selects the oldest mispredicted instruction. It sequences the ROB flush and then the fetch redirect. It also queues direction-predictor updates for every resolved conditional branch.

Parameters:
ADDR, `AddrWidth, instruction address width
ROB_DEPTH, `RobDepth, ROB entries
UPD_DEPTH, 4, predictor-update FIFO depth (power of 2, >=2)
ROB, $clog2(ROB_DEPTH), derived, not overridden

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
res_valid  in  1  resolution result valid this cycle
is_branch  in  1  result is a conditional branch (else jump)
rob_id  in  ROB  ROB tag of resolved instruction
br_res  in  1  branch outcome (`BrTaken/`BrNTaken)
pred_miss_  in  1  branch direction miss, active low
jump_miss_  in  1  jump target miss, active low
target_addr  in  ADDR  computed target (alu_res)
fall_addr  in  ADDR  sequential PC of the instruction
br_pc  in  ADDR  PC of the resolved instruction
rob_head  in  ROB  current ROB head (oldest tag)
flush_req  out  1  request ROB flush younger than flush_rob_id
flush_rob_id  out  ROB  tag of mispredicted instruction
flush_ack  in  1  ROB flush complete
redirect_valid  out  1  fetch redirect request
redirect_addr  out  ADDR  corrected fetch address
redirect_ready  in  1  fetch accepts redirect
upd_valid  out  1  predictor update available
upd_pc  out  ADDR  branch PC
upd_taken  out  1  actual outcome
upd_ready  in  1  predictor consumes update
recovering  out  1  FSM not IDLE; stalls issue

Behaviour:
- Miss event: res_valid && (!pred_miss_ || !jump_miss_). Redirect address: branch miss -> br_res taken ? target_addr : fall_addr; jump miss -> target_addr.
- Age: age(x) = (x - rob_head) mod ROB_DEPTH, ROB-bit wraparound subtraction. Smaller age is older.
- FSM states:
  - IDLE: on a miss event, capture rob_id and the redirect address, then go to FLUSH next cycle.
  - FLUSH: flush_req=1. Hold until flush_ack is sampled 1, then go to REDIRECT.
  - REDIRECT: redirect_valid=1, with redirect_addr stable. Hold until redirect_ready is sampled 1, then go to IDLE.
- A miss event in FLUSH with age strictly less than the captured tag replaces the captured tag and address and stays in FLUSH. flush_req remains high, and flush_rob_id updates the next cycle. A younger or equal miss is ignored.
- A miss event in REDIRECT is ignored; that instruction is already squashed.
- flush_ack and a replacing miss in the same cycle: the replacement wins and the FSM stays in FLUSH.
- recovering = (state != IDLE), registered.
- Update FIFO:
  - Push when res_valid && is_branch and the FSM is IDLE or in FLUSH with age <= captured age.
  - Push fields: {br_pc, br_res}.
  - Pop on upd_valid && upd_ready.
  - Simultaneous push and pop when full is allowed.
  - Push when full and no pop: the entry is dropped; predictor updates are best-effort.
  - upd_valid = !empty; outputs are taken from the head entry.
- All state changes occur at the clk edge.
- Reset (takes priority, including mid-recovery): state=IDLE, FIFO empty, captured tag/address=0. Outputs after reset: flush_req=0, flush_rob_id=0, redirect_valid=0, redirect_addr=0, upd_valid=0, upd_pc=0, upd_taken=0, recovering=0.
- Latency: a miss at cycle N gives flush_req=1 at N+1. Redirect is asserted the cycle after flush_ack is sampled.

Optional Feature:
BR_RECOVERY_STAT_EN:
- When defined, adds outputs stat_br_miss[31:0], stat_jump_miss[31:0] and stat_upd_drop[31:0].
- Counters are saturating and reset to 0. Each increments by 1 when its event is accepted: a captured or replaced miss of that type, or a dropped FIFO push.
- When undefined, these ports and counters do not exist and core behaviour is identical.

Test Plan:
- Reset, then a branch miss (rob_head=0, rob_id=5, br_res=taken, target=0x100) -> flush_req=1, flush_rob_id=5 next cycle. After flush_ack, redirect_valid=1 with addr 0x100. Redirect_ready returns the FSM to IDLE and drops recovering.
- Jump miss with target 0x2000 and fall 0x44 -> redirect_addr=0x2000. A not-taken branch miss -> redirect_addr=fall_addr.
- During FLUSH with rob_head=6 and captured tag 2 (age 4), a miss at tag 7 (age 1) -> flush_rob_id becomes 7. A subsequent miss at tag 3 is ignored.
- Replacing miss in the same cycle as flush_ack -> stays in FLUSH with the new tag; redirect carries the new address.
- Five correct branches with upd_ready=0 and UPD_DEPTH=4 -> four entries are kept in order and the fifth is dropped (stat_upd_drop=1 with BR_RECOVERY_STAT_EN). Draining yields the PCs in push order.
- Assert reset while in REDIRECT -> all outputs are 0 next cycle and the FIFO is empty.
